pmem_loader: RTL and testbench
==============================

// Module: pmem_loader
// PURPOSE
//  Boot-time program loader: consumes a byte stream from the UART receiver and
//  writes 18-bit instruction words into program memory through its write port
//  (addr, wenh, wenl, data_in). Holds the CPU in stall while loading. An
//  external mux selects between this block and the CPU for the pmem address.
// PARAMETERS
//  ADDR_WIDTH   16      pmem address width (matches `ADDR_WIDTH`)
//  PMEM_DEPTH   16384   number of pmem words; addresses >= PMEM_DEPTH are invalid
//  TIMEOUT      1000000 idle clocks allowed between bytes before aborting
// PORTS
//  clk          in   1           system clock
//  rst          in   1           asynchronous reset, active low
//  start        in   1           1-cycle pulse: begin a load session
//  base_addr    in   ADDR_WIDTH  first pmem word address, sampled on start
//  rx_data      in   8           byte from UART receiver
//  rx_valid     in   1           rx_data valid
//  rx_ready     out  1           loader accepts byte (transfer = valid & ready)
//  pm_addr      out  ADDR_WIDTH  pmem word address
//  pm_wenh      out  1           write pmem bits [17:16]
//  pm_wenl      out  1           write pmem bits [15:0]
//  pm_data      out  18          pmem write data
//  busy         out  1           session active; CPU held (and pmem mux to loader)
//  done         out  1           1-cycle pulse: session finished without error
//  error        out  1           sticky: session aborted; cleared by next start
// BEHAVIOUR
//  Reset: state IDLE; rx_ready=0, pm_wenh=pm_wenl=0, pm_addr=0, pm_data=0,
//   busy=0, done=0, error=0; word/timeout counters=0. Reset mid-session aborts
//   it immediately; no partial word is written.
//  Stream format: LEN_LO, LEN_HI (16-bit word count N, little endian), then N
//   groups of 3 bytes: B0[1:0]=word[17:16] (B0[7:2] ignored), B1=word[15:8],
//   B2=word[7:0].
//  States: IDLE -> (start) LEN_LO -> LEN_HI -> B0 -> B1 -> B2 -> WRITE -> B0 ...
//   -> DONE -> IDLE; any of LEN_LO..B2 -> ABORT -> IDLE.
//  IDLE: rx_ready=0; start latches base_addr into pm_addr, clears error,
//   busy=1 from next cycle. start while busy is ignored.
//  LEN_LO..B2: rx_ready=1; each accepted byte advances one state, resets
//   timeout counter. N=0 after LEN_HI -> DONE directly (no writes).
//  WRITE: exactly one cycle, rx_ready=0, pm_wenh=pm_wenl=1, pm_data=assembled
//   word at pm_addr. Next cycle pm_addr+=1, remaining count -=1; count 0 -> DONE
//   else B0. Write occurs 1 cycle after B2 is accepted.
//  Range: if pm_addr >= PMEM_DEPTH when entering WRITE, no write enables assert;
//   error set, go ABORT. pm_addr increment wraps modulo 2^ADDR_WIDTH (caught by
//   the range check for PMEM_DEPTH < 2^ADDR_WIDTH).
//  Timeout: counter increments each cycle in LEN_LO..B2 without a transfer;
//   reaching TIMEOUT sets error, goes ABORT. Already-written words stay written.
//  DONE: done=1 for one cycle, busy=0 next cycle. ABORT: error=1, busy=0 next
//   cycle, done stays 0.
//  rx_valid=1 with rx_ready=0 leaves the byte with the upstream (not dropped).
//  All outputs registered; pm_wenh and pm_wenl always assert together.
// TESTING
//  1) start, base=0x0010, bytes 02 00 | 03 AB CD | 01 12 34 -> pmem[0x10]=0x3ABCD,
//     pmem[0x11]=0x11234, done pulse, error=0, busy drops after done.
//  2) start, bytes 00 00 -> no write enable ever, done pulse 3 cycles after LEN_HI.
//  3) Stream 1 with rx_valid gapped 5 cycles per byte and held high during WRITE
//     -> identical pmem contents, no duplicated or lost byte.
//  4) TIMEOUT=50, start, 01 00 03 then silence -> error=1 at 50 idle cycles,
//     no write, busy=0, done never pulses.
//  5) base=PMEM_DEPTH-1, N=2 -> pmem[PMEM_DEPTH-1] written, second word not
//     written, error=1.
//  6) rst low after B1 accepted -> all outputs reset values, no write; new start
//     afterwards completes stream 1 correctly.

Source files
------------

// File: rtl/pmem_loader.sv
// pmem_loader
//   Boot-time program loader. Parses a byte stream from the UART receiver
//   (16-bit little-endian word count, then 3 bytes per 18-bit word) and writes
//   each word into program memory. busy holds the CPU and steers the pmem
//   address mux to this block for the whole session.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   start      1-cycle pulse, begins a session (ignored while busy)
//   base_addr  first word address, sampled on start
//   rx_data    byte from UART receiver
//   rx_valid   rx_data valid
//   rx_ready   loader accepts a byte (transfer = rx_valid & rx_ready)
//   pm_addr    pmem word address
//   pm_wenh    write enable for pmem bits [17:16]
//   pm_wenl    write enable for pmem bits [15:0]
//   pm_data    pmem write data
//   busy       session active
//   done       1-cycle pulse, session finished cleanly
//   error      sticky abort flag, cleared by the next start
module pmem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int PMEM_DEPTH = 16384,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic                  pm_wenh,
    output logic                  pm_wenl,
    output logic [17:0]           pm_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]         TO_LAST   = TW'(TIMEOUT - 1);
    // One extra bit so a depth of exactly 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(PMEM_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_WRITE, S_DONE, S_ABORT
    } state_t;

    state_t                  state_reg, state_next;
    logic                    rx_ready_reg;
    logic                    wen_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    error_reg;
    logic [ADDR_WIDTH-1:0]   pm_addr_reg;
    logic [17:0]             pm_data_reg;
    logic [15:0]             count_reg;
    logic [TW-1:0]           to_cnt_reg;

    logic xfer;
    logic timeout_hit;
    logic addr_ok;

    // rx_ready_reg is high exactly in LEN_LO..B2, so it doubles as the
    // "receiving" qualifier for the transfer and the timeout counter.
    assign xfer        = rx_valid & rx_ready_reg;
    assign timeout_hit = rx_ready_reg & ~rx_valid & (to_cnt_reg == TO_LAST);
    assign addr_ok     = {1'b0, pm_addr_reg} < DEPTH_EXT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer)             state_next = S_LEN_HI;
                else if (timeout_hit) state_next = S_ABORT;
            end
            S_LEN_HI: begin
                if (xfer)             state_next = ({rx_data, count_reg[7:0]} == 16'd0) ? S_DONE : S_B0;
                else if (timeout_hit) state_next = S_ABORT;
            end
            S_B0: begin
                if (xfer)             state_next = S_B1;
                else if (timeout_hit) state_next = S_ABORT;
            end
            S_B1: begin
                if (xfer)             state_next = S_B2;
                else if (timeout_hit) state_next = S_ABORT;
            end
            S_B2: begin
                // Range check happens here so an out-of-range word never
                // produces a write strobe.
                if (xfer)             state_next = addr_ok ? S_WRITE : S_ABORT;
                else if (timeout_hit) state_next = S_ABORT;
            end
            S_WRITE: begin
                state_next = (count_reg == 16'd1) ? S_DONE : S_B0;
            end
            S_DONE:  state_next = S_IDLE;
            S_ABORT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from state_next so they line up with the state
    // they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready_reg <= 1'b0;
            wen_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            pm_addr_reg  <= '0;
            pm_data_reg  <= '0;
            count_reg    <= '0;
            to_cnt_reg   <= '0;
        end else begin
            rx_ready_reg <= (state_next == S_LEN_LO) || (state_next == S_LEN_HI) ||
                            (state_next == S_B0) || (state_next == S_B1) ||
                            (state_next == S_B2);
            wen_reg      <= (state_next == S_WRITE);
            busy_reg     <= (state_next != S_IDLE);
            done_reg     <= (state_next == S_DONE);

            if (state_reg == S_IDLE && start) begin
                error_reg   <= 1'b0;
                pm_addr_reg <= base_addr;
            end
            if (state_next == S_ABORT) error_reg <= 1'b1;

            if (state_reg == S_WRITE) begin
                pm_addr_reg <= pm_addr_reg + 1'b1;
                count_reg   <= count_reg - 16'd1;
            end

            if (state_reg == S_IDLE || xfer) begin
                to_cnt_reg <= '0;
            end else if (rx_ready_reg) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end

            // pm_data doubles as the word assembly register.
            if (xfer) begin
                case (state_reg)
                    S_LEN_LO: count_reg[7:0]     <= rx_data;
                    S_LEN_HI: count_reg[15:8]    <= rx_data;
                    S_B0:     pm_data_reg[17:16] <= rx_data[1:0];
                    S_B1:     pm_data_reg[15:8]  <= rx_data;
                    S_B2:     pm_data_reg[7:0]   <= rx_data;
                    default:  ;
                endcase
            end
        end
    end

    assign rx_ready = rx_ready_reg;
    assign pm_wenh  = wen_reg;
    assign pm_wenl  = wen_reg;
    assign pm_addr  = pm_addr_reg;
    assign pm_data  = pm_data_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign error    = error_reg;

endmodule

// File: tb/tb_pmem_loader.sv
// Testbench for pmem_loader: expected pmem writes go into a scoreboard queue
// when a stream is issued; a negedge monitor pops and compares on each write.
module tb_pmem_loader;

    localparam int AW    = 16;
    localparam int DEPTH = 16384;
    localparam int TO    = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] pm_addr;
    logic          pm_wenh;
    logic          pm_wenl;
    logic [17:0]   pm_data;
    logic          busy;
    logic          done;
    logic          error;

    pmem_loader #(.ADDR_WIDTH(AW), .PMEM_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .pm_addr(pm_addr), .pm_wenh(pm_wenh), .pm_wenl(pm_wenl),
        .pm_data(pm_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [17:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the head of exp_q.
    always @(negedge clk) begin
        if (rst) begin
            if (done) done_cnt++;
            if (pm_wenh || pm_wenl) begin
                wr_cnt++;
                chk("wen_pair", {31'd0, pm_wenh}, {31'd0, pm_wenl});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none required", pm_addr, pm_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", {16'd0, pm_addr}, {16'd0, e.addr});
                    chk("write_data", {14'd0, pm_data}, {14'd0, e.data});
                end
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] base);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends tx_q. gap = idle cycles before each byte; b0_nogap presents each
    // word's first byte right after the previous B2, so valid stays high
    // through WRITE.
    task automatic send(input int gap, input bit b0_nogap);
        for (int i = 0; i < tx_q.size(); i++) begin
            int n;
            if (gap > 0 && !(b0_nogap && i >= 2 && ((i - 2) % 3) == 0)) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            n = 0;
            while (!rx_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL rx_ready_timeout: byte %0d never accepted, required acceptance", i);
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic stream1(input int gap, input bit b0_nogap, input string tag);
        int d0;
        exp_q.push_back('{addr: 16'h0010, data: 18'h3ABCD});
        exp_q.push_back('{addr: 16'h0011, data: 18'h11234});
        do_start(16'h0010);
        chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        tx_q = '{8'h02, 8'h00, 8'h03, 8'hAB, 8'hCD, 8'h01, 8'h12, 8'h34};
        d0 = done_cnt;
        send(gap, b0_nogap);
        wait_done({tag, "_done"}, 20);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        @(negedge clk);
        chk({tag, "_busy_dropped"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_once"}, done_cnt - d0, 32'd1);
        chk({tag, "_all_written"}, exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_wen"}, {30'd0, pm_wenh, pm_wenl}, 32'd0);
        chk({tag, "_pm_addr"}, {16'd0, pm_addr}, 32'd0);
        chk({tag, "_pm_data"}, {14'd0, pm_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        int w0, d0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1) basic two-word load
        stream1(0, 1'b0, "t1");

        // 2) zero-length session
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(16'h0040);
        tx_q = '{8'h00, 8'h00};
        send(0, 1'b0);
        wait_done("t2_done_within_3", 3);
        @(negedge clk);
        chk("t2_no_write", wr_cnt - w0, 32'd0);
        chk("t2_done_once", done_cnt - d0, 32'd1);
        chk("t2_error", {31'd0, error}, 32'd0);

        // 3) gapped stream, valid held through WRITE
        stream1(5, 1'b1, "t3");

        // 4) timeout after 01 00 03
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(16'h0100);
        tx_q = '{8'h01, 8'h00, 8'h03};
        send(0, 1'b0);
        repeat (TO - 1) @(negedge clk);
        chk("t4_no_error_before_timeout", {31'd0, error}, 32'd0);
        @(negedge clk);
        chk("t4_error_at_timeout", {31'd0, error}, 32'd1);
        @(negedge clk);
        chk("t4_busy_dropped", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_error_sticky", {31'd0, error}, 32'd1);
        chk("t4_no_write", wr_cnt - w0, 32'd0);
        chk("t4_no_done", done_cnt - d0, 32'd0);

        // 5) range: last valid word written, next one refused
        w0 = wr_cnt;
        d0 = done_cnt;
        exp_q.push_back('{addr: 16'(DEPTH - 1), data: 18'h10005});
        do_start(16'(DEPTH - 1));
        chk("t5_error_cleared_by_start", {31'd0, error}, 32'd0);
        tx_q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h05, 8'h02, 8'h00, 8'h07};
        send(0, 1'b0);
        repeat (2) @(negedge clk);
        chk("t5_error", {31'd0, error}, 32'd1);
        chk("t5_busy_dropped", {31'd0, busy}, 32'd0);
        chk("t5_one_write", wr_cnt - w0, 32'd1);
        chk("t5_no_done", done_cnt - d0, 32'd0);
        chk("t5_all_written", exp_q.size(), 32'd0);

        // 6) reset after B1, then a clean session
        w0 = wr_cnt;
        do_start(16'h0020);
        tx_q = '{8'h02, 8'h00, 8'h03, 8'hAB};
        send(0, 1'b0);
        #1 rst = 1'b0;
        #1 chk_reset_state("t6_async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_no_write", wr_cnt - w0, 32'd0);
        stream1(0, 1'b0, "t6_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
